// File: rtl/disp_mode_ctrl_pkg.sv
// Shared encodings for the display mode controller: mode values, remote
// command codes, debounce FSM states and 8-bit saturating arithmetic.
package disp_mode_ctrl_pkg;

  localparam logic [1:0] MODE_RGB      = 2'd0;
  localparam logic [1:0] MODE_GRAY     = 2'd1;
  localparam logic [1:0] MODE_BINARY   = 2'd2;
  localparam logic [1:0] MODE_GRAY_EXT = 2'd3;

  localparam logic [7:0] CMD_RGB    = 8'h01;
  localparam logic [7:0] CMD_GRAY   = 8'h02;
  localparam logic [7:0] CMD_BINARY = 8'h04;
  localparam logic [7:0] CMD_THRESH = 8'h08;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_WAIT_PRESS,
    DB_PRESSED,
    DB_WAIT_RELEASE
  } db_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // A borrow out of bit 7 lands in bit 8 of the 9-bit difference.
  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[8] ? 8'h00 : s[7:0];
  endfunction

endpackage

// File: rtl/disp_mode_ctrl_key_debounce.sv
// One button: 2-flop synchroniser followed by a press/release debounce FSM
// that emits a single-cycle pulse per accepted press.
module key_debounce
  import disp_mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_evt
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic          key_s;
  db_state_e     state_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic          evt_q;

  always_comb sync_d = {sync_q[0], key_raw};
  assign key_s   = sync_q[1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      evt_q <= 1'b0;
      case (state_q)
        DB_IDLE:
          if (key_s) begin
            state_q <= DB_WAIT_PRESS;
            cnt_q   <= '0;
          end
        DB_WAIT_PRESS:
          if (!key_s) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= DB_PRESSED;
            cnt_q   <= '0;
            evt_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        DB_PRESSED: state_q <= DB_WAIT_RELEASE;
        // Any bounce back to 1 restarts the release window.
        DB_WAIT_RELEASE:
          if (key_s) begin
            cnt_q <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        default: begin
          state_q <= DB_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign key_evt = evt_q;

endmodule

// File: rtl/disp_mode_ctrl.sv
// Display mode / binarisation threshold controller driven by debounced keys and
// remote commands. Define DISP_MODE_CTRL_FRAME_SYNC_EN to commit only at i_vs rising edges.
module disp_mode_ctrl
  import disp_mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int THRESH_INIT  = 40,
  parameter int THRESH_STEP  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key,
  input  logic [7:0] disp_model,
  input  logic [7:0] threshold_set,
  input  logic       i_vs,
  output logic [1:0] mode_sel,
  output logic [7:0] threshold,
  output logic       cfg_update,
  output logic [2:0] key_evt
);

  localparam logic [7:0] T_INIT = 8'(THRESH_INIT);
  localparam logic [7:0] T_STEP = 8'(THRESH_STEP);

  logic [2:0] evt;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key[i]),
      .key_evt (evt[i])
    );
  end

  logic [1:0] pend_mode_q, pend_mode_d, mode_q, mode_d;
  logic [7:0] pend_thr_q, pend_thr_d, thr_q, thr_d;
  logic       cfg_q, cfg_d;
  logic [1:0] thr_keys;

  always_comb begin
    pend_mode_d = pend_mode_q;
    if (evt[0])                        pend_mode_d = pend_mode_q + 2'd1;
    else if (disp_model == CMD_RGB)    pend_mode_d = MODE_RGB;
    else if (disp_model == CMD_GRAY)   pend_mode_d = MODE_GRAY;
    else if (disp_model == CMD_BINARY) pend_mode_d = MODE_BINARY;

    // Step keys only act in binary mode; both at once cancel and still block the remote load.
    thr_keys   = (mode_q == MODE_BINARY) ? evt[2:1] : 2'b00;
    pend_thr_d = pend_thr_q;
    if (thr_keys == 2'b01)      pend_thr_d = sat_add8(pend_thr_q, T_STEP);
    else if (thr_keys == 2'b10) pend_thr_d = sat_sub8(pend_thr_q, T_STEP);
    else if (thr_keys == 2'b00 && disp_model == CMD_THRESH) pend_thr_d = threshold_set;
  end

`ifdef DISP_MODE_CTRL_FRAME_SYNC_EN
  logic vs_q;
  logic frame_edge;

  always_ff @(posedge clk) begin
    if (rst) vs_q <= 1'b0;
    else     vs_q <= i_vs;
  end

  // Commit takes the pending value from before this cycle's update.
  assign frame_edge = i_vs & ~vs_q;

  always_comb begin
    mode_d = frame_edge ? pend_mode_q : mode_q;
    thr_d  = frame_edge ? pend_thr_q  : thr_q;
  end
`else
  logic unused_vs;
  assign unused_vs = i_vs;

  always_comb begin
    mode_d = pend_mode_d;
    thr_d  = pend_thr_d;
  end
`endif

  assign cfg_d = (mode_d != mode_q) || (thr_d != thr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mode_q <= MODE_RGB;
      pend_thr_q  <= T_INIT;
      mode_q      <= MODE_RGB;
      thr_q       <= T_INIT;
      cfg_q       <= 1'b0;
    end else begin
      pend_mode_q <= pend_mode_d;
      pend_thr_q  <= pend_thr_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      cfg_q       <= cfg_d;
    end
  end

  assign mode_sel   = mode_q;
  assign threshold  = thr_q;
  assign cfg_update = cfg_q;
  assign key_evt    = evt;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Scoreboarded bench for disp_mode_ctrl: stimulus tasks feed a behavioural model
// that queues expected key pulses and config changes; a negedge monitor checks them.
module tb_disp_mode_ctrl;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key = '0;
  logic [7:0] disp_model = '0;
  logic [7:0] threshold_set = '0;
  logic       i_vs = 1'b0;
  logic [1:0] mode_sel;
  logic [7:0] threshold;
  logic       cfg_update;
  logic [2:0] key_evt;

  disp_mode_ctrl #(.DEBOUNCE_CYC(DEB), .THRESH_INIT(40), .THRESH_STEP(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .key           (key),
    .disp_model    (disp_model),
    .threshold_set (threshold_set),
    .i_vs          (i_vs),
    .mode_sel      (mode_sel),
    .threshold     (threshold),
    .cfg_update    (cfg_update),
    .key_evt       (key_evt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int mode; int thr;} cfg_t;
  cfg_t cfg_exp[$];
  int   evt_exp[$];
  int   m_pmode = 0, m_pthr = 40, m_amode = 0, m_athr = 40;

  function automatic void m_commit();
    if (m_pmode != m_amode || m_pthr != m_athr) cfg_exp.push_back('{m_pmode, m_pthr});
    m_amode = m_pmode;
    m_athr  = m_pthr;
  endfunction

  function automatic void m_updated();
`ifndef DISP_MODE_CTRL_FRAME_SYNC_EN
    m_commit();
`endif
  endfunction

  function automatic void m_key(input int k);
    evt_exp.push_back(k);
    if (k == 0) m_pmode = (m_pmode + 1) % 4;
    else if (m_amode == 2) begin
      if (k == 1) m_pthr = (m_pthr + 5 > 255) ? 255 : m_pthr + 5;
      else        m_pthr = (m_pthr - 5 < 0)   ? 0   : m_pthr - 5;
    end
    m_updated();
  endfunction

  function automatic void m_cmd(input int c, input int ts);
    if (c == 1)      m_pmode = 0;
    else if (c == 2) m_pmode = 1;
    else if (c == 4) m_pmode = 2;
    else if (c == 8) m_pthr  = ts;
    m_updated();
  endfunction

  function automatic void m_reset();
    m_pmode = 0; m_pthr = 40; m_amode = 0; m_athr = 40;
    cfg_exp.delete();
    evt_exp.delete();
  endfunction

  // ---------------- monitor ----------------
  int   prev_mode = 0, prev_thr = 40;
  cfg_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_mode = 0;
      prev_thr  = 40;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (key_evt[k]) begin
          if (evt_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL evt_extra key=%0d got pulse want none", k);
          end else chk("evt_key", k, evt_exp.pop_front());
        end
      end
      if (cfg_update) begin
        if (cfg_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL cfg_extra got mode=%0d thr=%0d want no update", mode_sel, threshold);
        end else begin
          mon_e = cfg_exp.pop_front();
          chk("cfg_mode", int'(mode_sel), mon_e.mode);
          chk("cfg_thr", int'(threshold), mon_e.thr);
        end
      end
      chk("cfg_vs_change", int'(cfg_update),
          (int'(mode_sel) != prev_mode || int'(threshold) != prev_thr) ? 1 : 0);
      prev_mode = int'(mode_sel);
      prev_thr  = int'(threshold);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input int c, input int ts);
    m_cmd(c, ts);
    disp_model    = 8'(c);
    threshold_set = 8'(ts);
    tick(1);
    disp_model = '0;
    tick(2);
  endtask

  task automatic frame();
    i_vs = 1'b1;
`ifdef DISP_MODE_CTRL_FRAME_SYNC_EN
    m_commit();
`endif
    tick(1);
    chk("frame_mode", int'(mode_sel), m_amode);
    chk("frame_thr", int'(threshold), m_athr);
    tick(2);
    i_vs = 1'b0;
    tick(3);
  endtask

  // Clean press; optional command c is driven in the key_evt cycle.
  task automatic press(input int k, input int hold, input int rel, input int c);
    int seen;
    bit chk_next;
    seen = 0;
    chk_next = 0;
    m_key(k);
    key[k] = 1'b1;
    for (int i = 0; i < hold + rel; i++) begin
      if (i == hold) key[k] = 1'b0;
      tick(1);
      disp_model = '0;
      if (chk_next) begin
        chk("mode_after_evt", int'(mode_sel), m_amode);
        chk("thr_after_evt", int'(threshold), m_athr);
        chk_next = 0;
      end
      if (key_evt[k]) begin
        seen++;
        chk_next = 1;
        if (c != 0) disp_model = 8'(c);
      end
    end
    chk("press_pulses", seen, 1);
  endtask

  logic [7:0] cmd_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h03, 8'h10, 8'h80, 8'hFF};

  initial begin
    int r;
    int lat;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_mode", int'(mode_sel), 0);
    chk("rst_thr", int'(threshold), 40);
    chk("rst_cfg", int'(cfg_update), 0);
    chk("rst_evt", int'(key_evt), 0);

    // key[0] held 40 cycles, then boundary
    press(0, 40, 30, 0);
    frame();
    chk("mode_after_frame", int'(mode_sel), 1);

    // bouncing key then stable press
    repeat (4) begin
      key[0] = 1'b1; tick(5);
      key[0] = 1'b0; tick(3);
    end
    press(0, 40, 30, 0);

    // threshold saturation in binary mode
    cmd(8'h04, 0);
    cmd(8'h08, 253);
    frame();
    press(1, 35, 30, 0);
    frame();
    chk("thr_sat_hi", int'(threshold), 255);
    press(2, 35, 30, 0);
    press(2, 35, 30, 0);
    frame();
    chk("thr_dec_twice", int'(threshold), 245);

    // threshold keys ignored outside binary mode, remote load applies
    cmd(8'h01, 0);
    frame();
    press(1, 35, 30, 0);
    frame();
    chk("thr_key_ignored", int'(threshold), 245);
    cmd(8'h08, 100);
    frame();
    chk("thr_remote", int'(threshold), 100);

    // key advance beats disp_model in the same cycle, from mode 3
    press(0, 35, 30, 0);
    press(0, 35, 30, 0);
    press(0, 35, 30, 0);
    frame();
    chk("mode_three", int'(mode_sel), 3);
    press(0, 35, 30, 8'h04);
    frame();
    chk("same_cycle_mode", int'(mode_sel), 0);

    // reset mid-count with a pending mode
    cmd(8'h04, 0);
    key[0] = 1'b1;
    tick(8);
    chk("q_evt_empty_pre_rst", evt_exp.size(), 0);
    chk("q_cfg_empty_pre_rst", cfg_exp.size(), 0);
    rst = 1'b1;
    key[0] = 1'b0;
    tick(2);
    m_reset();
    rst = 1'b0;
    tick(1);
    chk("midrst_mode", int'(mode_sel), 0);
    chk("midrst_thr", int'(threshold), 40);
    chk("midrst_cfg", int'(cfg_update), 0);
    tick(30);
    frame();
    chk("midrst_mode_frame", int'(mode_sel), 0);

    // key held across reset release
    key[0] = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    m_reset();
    m_key(0);
    lat = -1;
    for (int i = 0; i < DEB + 10; i++) begin
      tick(1);
      if (key_evt[0]) begin
        lat = i + 1;
        break;
      end
    end
    chk("held_rst_latency_ok", (lat >= DEB && lat <= DEB + 4) ? 1 : 0, 1);
    key[0] = 1'b0;
    tick(30);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 6);
      case (r)
        0, 1: press($urandom_range(0, 2), $urandom_range(30, 45), $urandom_range(25, 40), 0);
        2:    cmd(8'h04, 0);
        3:    cmd(int'(cmd_tab[$urandom_range(0, 7)]), $urandom_range(0, 255));
        4, 5: frame();
        default: tick($urandom_range(1, 10));
      endcase
    end

    tick(40);
    chk("final_evt_q_empty", evt_exp.size(), 0);
    chk("final_cfg_q_empty", cfg_exp.size(), 0);
    chk("final_mode", int'(mode_sel), m_amode);
    chk("final_thr", int'(threshold), m_athr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/disp_mode_ctrl.md
DISP_MODE_CTRL -- requirements
Module: disp_mode_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEBOUNCE_CYC, 1000000: cycles a key level must stay stable before it is accepted.
- THRESH_INIT, 40: binarisation threshold after reset.
- THRESH_STEP, 5: threshold increment/decrement per key press.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: pixel clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- key, in, 3: raw asynchronous buttons, active-high. [0] = mode advance, [1] = threshold up, [2] = threshold down.
- disp_model, in, 8: one-hot remote command.
- threshold_set, in, 8: remote threshold value.
- i_vs, in, 1: vertical sync of the video stream.
- mode_sel, out, 2: active display mode. 0 = RGB, 1 = gray, 2 = binary, 3 = gray-extend.
- threshold, out, 8: active binarisation threshold.
- cfg_update, out, 1: one-cycle pulse when an active value changes.
- key_evt, out, 3: one-cycle debounced press pulses, for status use.
REQ-003 There SHALL be exactly one clock (clk); reset SHALL be synchronous and active-high (rst).

Function
REQ-004 Each key bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-005 Each key SHALL have an independent debounce FSM with states IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
- IDLE -> WAIT_PRESS on sync=1.
- WAIT_PRESS -> IDLE on sync=0, which clears the counter.
- WAIT_PRESS -> PRESSED after DEBOUNCE_CYC consecutive cycles of sync=1.
- PRESSED -> WAIT_RELEASE unconditionally.
- WAIT_RELEASE -> IDLE after DEBOUNCE_CYC consecutive cycles of sync=0. A 1 during this count SHALL restart the count.
REQ-006 key_evt[n] SHALL be 1 for exactly the one cycle that FSM n is in PRESSED; each physical press SHALL produce exactly one pulse.
REQ-007 Each debounce counter SHALL be wide enough to hold DEBOUNCE_CYC and SHALL saturate rather than wrap.
REQ-008 Pending mode update:
- key_evt[0] SHALL advance pending mode by 1 modulo 4 (3 -> 0).
- Otherwise, disp_model 8'h01, 8'h02 and 8'h04 SHALL load pending mode 0, 1 and 2 respectively.
- key_evt[0] SHALL win over disp_model in the same cycle.
REQ-009 Pending threshold update:
- key_evt[1] SHALL add THRESH_STEP, saturating at 255. This SHALL apply only while active mode = 2.
- key_evt[2] SHALL subtract THRESH_STEP, saturating at 0. This SHALL apply only while active mode = 2.
- key_evt[1] and key_evt[2] in the same cycle SHALL leave pending threshold unchanged.
- disp_model 8'h08 SHALL load threshold_set into pending threshold, in any mode, with priority below key_evt[1]/key_evt[2].
REQ-010 disp_model values other than 8'h01, 8'h02, 8'h04 and 8'h08 SHALL be ignored.
REQ-011 Saturation arithmetic SHALL use 9-bit intermediates; for example, 253 + 5 = 255 and 3 - 5 = 0.
REQ-012 A frame boundary SHALL be a rising edge of registered i_vs: i_vs=1 while the previous sample is 0.
REQ-013 In the frame-boundary cycle, mode_sel and threshold SHALL load the pending values; the new values are visible on the next cycle.
REQ-014 cfg_update SHALL pulse in the same cycle mode_sel or threshold takes a different value, and SHALL stay 0 when a commit leaves both unchanged.
REQ-015 A pending update in the same cycle as a frame boundary SHALL be committed at the next boundary, not the current one.

Reset
REQ-016 On rst=1 at a clock edge, these SHALL load their reset values:
- mode_sel and pending mode: 0.
- threshold and pending threshold: THRESH_INIT.
- cfg_update and key_evt: 0.
- debounce FSMs: IDLE, with counters 0.
- synchroniser and i_vs history registers: 0.
REQ-017 Reset asserted in the middle of a debounce count or with a commit pending SHALL discard that count and that pending value.
REQ-018 A key still held when reset releases SHALL produce one key_evt after DEBOUNCE_CYC cycles.

Configuration
REQ-019 With DISP_MODE_CTRL_FRAME_SYNC_EN defined, active values SHALL change only at frame boundaries (REQ-012..REQ-015).
REQ-020 Without DISP_MODE_CTRL_FRAME_SYNC_EN, active values SHALL equal pending values one cycle after each update, i_vs SHALL be unused, and cfg_update SHALL pulse on each change.

Structure
REQ-021 A shared package SHALL hold:
- the mode encoding constants MODE_RGB, MODE_GRAY, MODE_BINARY and MODE_GRAY_EXT;
- the disp_model command constants;
- the debounce FSM state typedef.
REQ-022 The debounce logic SHALL be a sub-module, key_debounce, instantiated once per key.

Verification
REQ-023 The bench SHALL cover these directed scenarios (DEBOUNCE_CYC=16, frame sync on unless stated):
- key[0] held 40 cycles, then a frame boundary -> one key_evt[0]; mode_sel 0->1 the cycle after the boundary; one cfg_update.
- key[0] bouncing with 1s of 5 cycles, then stable -> one key_evt[0] only.
- Mode 2, threshold 253, key[1] press, boundary -> threshold 255. Then key[2] pressed twice, boundary -> threshold 245.
- Mode 0, key[1] press -> threshold unchanged, no cfg_update. Then disp_model=8'h08 with threshold_set=100, boundary -> threshold 100.
- key_evt[0] and disp_model=8'h04 in the same cycle, from mode 3 -> pending mode 0.
- rst pulsed mid-count with pending mode 2 -> mode_sel 0, threshold 40. With the macro undefined -> mode_sel updates one cycle after key_evt, independent of i_vs.
